// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared states and word-packing constants for the boot loader
package program_loader_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_ADDR_SHIFT = 2;
endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: packs accepted bytes little-endian into a 32-bit word
module loader_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_q,
  output logic        last_byte
);
  logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx;
  assign last_byte = byte_idx == $bits(byte_idx)'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (load_en) begin
      byte_idx <= byte_idx + 1'b1;
      word_q[{byte_idx, 3'b000} +: 8] <= byte_data;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams bytes into instruction memory and holds the core in reset until loaded
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [63:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, word_idx;
  logic [31:0] word_q;
  logic last_byte, last_word, take;
  assign take = state == IDLE && start;
  assign last_word = word_idx == len_q - LEN_W'(1);
  loader_word_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clear(take),
    .load_en(state == RECV && byte_valid),
    .byte_data(byte_data),
    .word_q(word_q),
    .last_byte(last_byte)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      word_idx <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        len_q    <= len_words;
        word_idx <= '0;
      end
      if (state == WRITE && !last_word) word_idx <= word_idx + 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : len_words == '0 ? DONE : len_words > LEN_W'(DEPTH) ? ERROR : RECV;
      RECV:    state_n = byte_valid && last_byte ? WRITE : RECV;
      WRITE:   state_n = last_word ? DONE : RECV;
      default: state_n = state;
    endcase
    byte_ready = state == RECV;
    imem_we    = state == WRITE;
    imem_addr  = 64'(word_idx) << WORD_ADDR_SHIFT;
    imem_wdata = word_q;
    core_reset = state != DONE;
    busy       = state == RECV || state == WRITE;
    done       = state == DONE;
    error      = state == ERROR;
  end
endmodule
